// File: rtl/alu_arbiter_if.sv
// Request/response/ALU bundle for alu_arbiter.
// master = requesters + shared ALU, slave = arbiter.
interface alu_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req1_valid;
  logic              req0_ready;
  logic              req1_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req0_b;
  logic [DATA_W-1:0] req1_b;
  logic [5:0]        req0_aluc;
  logic [5:0]        req1_aluc;
  logic              rsp0_valid;
  logic              rsp1_valid;
  logic              rsp0_ready;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [5:0]        alu_aluc;
  logic [DATA_W-1:0] alu_result;
  logic              busy;

  modport master (
    output req0_valid, req1_valid,
    output req0_a, req1_a, req0_b, req1_b,
    output req0_aluc, req1_aluc,
    output rsp0_ready, rsp1_ready,
    output alu_result,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid,
    input  rsp_result,
    input  alu_a, alu_b, alu_aluc,
    input  busy
  );

  modport slave (
    input  req0_valid, req1_valid,
    input  req0_a, req1_a, req0_b, req1_b,
    input  req0_aluc, req1_aluc,
    input  rsp0_ready, rsp1_ready,
    input  alu_result,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid,
    output rsp_result,
    output alu_a, alu_b, alu_aluc,
    output busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for one shared ALU, one op in flight.
// ALU_ARB_RR_EN selects round-robin; otherwise req0 has priority.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input logic        clk,
  input logic        rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t            state;
  logic              owner;
  logic              gnt0;
  logic              gnt1;
  logic              accept;
  logic              rsp_hs;
  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] b_sel;
  logic [5:0]        aluc_sel;

`ifdef ALU_ARB_RR_EN
  // last = 1 means req1 won the previous accept
  logic last;

  always_comb begin
    gnt1 = bus.req1_valid &&
           (!bus.req0_valid || !last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= gnt1;
    end
  end
`else
  always_comb begin
    gnt1 = bus.req1_valid && !bus.req0_valid;
  end
`endif

  always_comb begin
    gnt0 = bus.req0_valid && !gnt1;
    bus.req0_ready = !rst && (state == IDLE) && gnt0;
    bus.req1_ready = !rst && (state == IDLE) && gnt1;
    accept   = bus.req0_ready || bus.req1_ready;
    rsp_hs   = owner ? bus.rsp1_ready : bus.rsp0_ready;
    a_sel    = gnt1 ? bus.req1_a    : bus.req0_a;
    b_sel    = gnt1 ? bus.req1_b    : bus.req0_b;
    aluc_sel = gnt1 ? bus.req1_aluc : bus.req0_aluc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      owner          <= 1'b0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_aluc   <= '0;
      bus.rsp_result <= '0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            bus.alu_a    <= a_sel;
            bus.alu_b    <= b_sel;
            bus.alu_aluc <= aluc_sel;
            owner        <= gnt1;
            bus.busy     <= 1'b1;
            state        <= EXEC;
          end
        end
        EXEC: begin
          bus.rsp_result <= bus.alu_result;
          bus.rsp0_valid <= !owner;
          bus.rsp1_valid <= owner;
          state          <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            bus.busy       <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter with a behavioural ALU.
// Expectations follow ALU_ARB_RR_EN when it is defined.
module tb_alu_arbiter;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b001000;
  localparam logic [5:0] OP_AND = 6'b000010;
  localparam logic [5:0] OP_OR  = 6'b001010;
  localparam logic [5:0] OP_XOR = 6'b000100;
  localparam logic [5:0] OP_LUI = 6'b001100;
  localparam logic [5:0] OP_SHL = 6'b000101;
  localparam logic [5:0] OP_SRL = 6'b001101;
  localparam logic [5:0] OP_SRA = 6'b011101;

`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        id;
    logic [31:0] res;
  } exp_t;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  exp_t sb[$];

  alu_arbiter_if #(.DATA_W(32)) bus ();

  alu_arbiter #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.alu_result = '0;
    case (bus.alu_aluc)
      OP_ADD: bus.alu_result = bus.alu_a + bus.alu_b;
      OP_SUB: bus.alu_result = bus.alu_a - bus.alu_b;
      OP_AND: bus.alu_result = bus.alu_a & bus.alu_b;
      OP_OR:  bus.alu_result = bus.alu_a | bus.alu_b;
      OP_XOR: bus.alu_result = bus.alu_a ^ bus.alu_b;
      OP_LUI: bus.alu_result = {bus.alu_b[15:0], 16'h0};
      OP_SHL: bus.alu_result = bus.alu_a << bus.alu_b[4:0];
      OP_SRL: bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
      OP_SRA: bus.alu_result =
                32'($signed(bus.alu_a) >>> bus.alu_b[4:0]);
      default: bus.alu_result = '0;
    endcase
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [5:0] c);
    bus.req0_a     = a;
    bus.req0_b     = b;
    bus.req0_aluc  = c;
    bus.req0_valid = 1'b1;
  endtask

  task automatic drive1(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [5:0] c);
    bus.req1_a     = a;
    bus.req1_b     = b;
    bus.req1_aluc  = c;
    bus.req1_valid = 1'b1;
  endtask

  // Expects an accept for requester g1 at the coming edge.
  task automatic grant(input string tag,
                       input logic g1,
                       input logic [31:0] res);
    exp_t e;
    @(negedge clk);
    check({tag, "_rdy0"}, 32'(bus.req0_ready), 32'(!g1));
    check({tag, "_rdy1"}, 32'(bus.req1_ready), 32'(g1));
    e.id  = g1;
    e.res = res;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Called right after the accept edge; response is due two cycles later.
  task automatic collect(input string tag, input int stall);
    exp_t e;
    @(negedge clk);
    check({tag, "_exec_v"},
          32'(bus.rsp0_valid || bus.rsp1_valid), 32'(0));
    check({tag, "_exec_busy"}, 32'(bus.busy), 32'(1));
    @(negedge clk);
    e = sb.pop_front();
    check({tag, "_v0"}, 32'(bus.rsp0_valid), 32'(!e.id));
    check({tag, "_v1"}, 32'(bus.rsp1_valid), 32'(e.id));
    check({tag, "_res"}, bus.rsp_result, e.res);
    for (int s = 0; s < stall; s++) begin
      bus.rsp0_ready = e.id;
      bus.rsp1_ready = !e.id;
      @(posedge clk);
      #1;
      @(negedge clk);
      check({tag, "_hold_v"},
            32'(e.id ? bus.rsp1_valid : bus.rsp0_valid), 32'(1));
      check({tag, "_hold_res"}, bus.rsp_result, e.res);
      check({tag, "_hold_rdy0"}, 32'(bus.req0_ready), 32'(0));
      check({tag, "_hold_rdy1"}, 32'(bus.req1_ready), 32'(0));
      check({tag, "_hold_busy"}, 32'(bus.busy), 32'(1));
    end
    bus.rsp0_ready = !e.id;
    bus.rsp1_ready = e.id;
    @(posedge clk);
    #1;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
  endtask

  initial begin
    logic g;
    n_assert       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req0_aluc  = '0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.req1_aluc  = '0;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    bus.req0_valid = 1'b1;
    @(negedge clk);
    check("rst_rdy0", 32'(bus.req0_ready), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_v0", 32'(bus.rsp0_valid), 32'(0));
    check("rst_v1", 32'(bus.rsp1_valid), 32'(0));
    check("rst_alu_a", bus.alu_a, 32'h0);
    check("rst_alu_b", bus.alu_b, 32'h0);
    check("rst_aluc", 32'(bus.alu_aluc), 32'h0);
    check("rst_res", bus.rsp_result, 32'h0);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    rst            = 1'b0;

    drive0(32'd20, 32'd5, OP_SUB);
    drive1(32'hAAAAAAAA, 32'h55555555, OP_XOR);
    for (int i = 0; i < 4; i++) begin
      g = RR ? i[0] : 1'b0;
      grant("tie", g, g ? 32'hFFFFFFFF : 32'h0000000F);
      collect("tie", 0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    drive0(32'd10, 32'd5, OP_ADD);
    grant("add", 1'b0, 32'd15);
    bus.req0_valid = 1'b0;
    collect("add", 0);

    drive0(32'hFFFFFFFF, 32'd1, OP_ADD);
    grant("opchg", 1'b0, 32'h0);
    bus.req0_a     = 32'h0;
    bus.req0_valid = 1'b0;
    collect("opchg", 0);

    bus.req1_valid = 1'b1;
    #3;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check("drop_rdy1", 32'(bus.req1_ready), 32'(0));
    @(posedge clk);
    #1;
    check("drop_busy", 32'(bus.busy), 32'(0));

    drive1(32'h80000000, 32'd1, OP_SRA);
    grant("sra", 1'b1, 32'hC0000000);
    bus.req1_valid = 1'b0;
    drive0(32'hFF00FF00, 32'h0F0F0F0F, OP_AND);
    collect("sra", 5);
    check("hold_alu_a", bus.alu_a, 32'h80000000);
    check("hold_aluc", 32'(bus.alu_aluc), 32'(OP_SRA));
    grant("and", 1'b0, 32'h0F000F00);
    bus.req0_valid = 1'b0;
    collect("and", 0);

    drive0(32'd1, 32'd2, OP_OR);
    grant("or", 1'b0, 32'd3);
    rst = 1'b1;
    drive0(32'd20, 32'd5, OP_SUB);
    drive1(32'hAAAAAAAA, 32'h55555555, OP_XOR);
    @(negedge clk);
    check("rst_exec_rdy0", 32'(bus.req0_ready), 32'(0));
    check("rst_exec_rdy1", 32'(bus.req1_ready), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb.pop_back());
    check("rst_exec_busy", 32'(bus.busy), 32'(0));
    check("rst_exec_v",
          32'(bus.rsp0_valid || bus.rsp1_valid), 32'(0));
    grant("post_rst", 1'b0, 32'h0000000F);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    collect("post_rst", 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
